regfile_write_arbiter: RTL and testbench

- Shares the single effective register-file write path among 4 independent writeback requesters.
- The register file honours only one write per cycle, by fixed priority, and silently drops the rest.
- Each requester gets a 1-entry holding buffer with a valid/ready handshake. A round-robin arbiter issues exactly one registered write per cycle to register-file write port 0.
- A pending-write mask is exported so the read side can stall on in-flight destinations.

---
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus and register-file write port shared by the arbiter and its requesters.
// Requester i uses slice i of reqAddr/reqData.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [3:0]                 reqValid;
  logic [4*ADDR_WIDTH-1:0]    reqAddr;
  logic [4*DATA_WIDTH-1:0]    reqData;
  logic [3:0]                 reqReady;
  logic                       wrEnable;
  logic [ADDR_WIDTH-1:0]      wrAddr;
  logic [DATA_WIDTH-1:0]      wrData;
  logic [2**ADDR_WIDTH-1:0]   pendingMask;
  logic                       idle;
  logic [CNT_WIDTH-1:0]       conflictCount;

  modport master (
    output reqValid, reqAddr, reqData,
    input  reqReady, wrEnable, wrAddr, wrData, pendingMask, idle, conflictCount
  );

  modport slave (
    input  reqValid, reqAddr, reqData,
    output reqReady, wrEnable, wrAddr, wrData, pendingMask, idle, conflictCount
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Funnels four writeback requesters through per-requester 1-entry buffers and a round-robin
// arbiter onto a single registered register-file write port.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned NumReq  = 4;
  localparam int unsigned NumRegs = 2**ADDR_WIDTH;

  logic [NumReq-1:0]     buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q [NumReq];
  logic [DATA_WIDTH-1:0] buf_data_q [NumReq];
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0]  conflict_q, conflict_d;

  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic [NumReq-1:0]     accept;
  logic [2:0]            num_valid;
  logic [NumRegs-1:0]    pending;

  // First valid buffer at or after rr_ptr_q, wrapping modulo 4.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    for (int k = 0; k < NumReq; k++) begin
      if (!grant_valid && buf_valid_q[rr_ptr_q + 2'(k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr_q + 2'(k);
      end
    end
  end

  // Writes to register 0 complete the handshake but never occupy the buffer.
  always_comb begin
    accept    = '0;
    num_valid = '0;
    for (int i = 0; i < NumReq; i++) begin
      accept[i] = bus.reqValid[i] && !buf_valid_q[i] &&
                  (bus.reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
      num_valid = num_valid + 3'(buf_valid_q[i]);
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = grant_valid;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    conflict_d  = conflict_q;
    if (grant_valid) begin
      buf_valid_d[grant_idx] = 1'b0;
      rr_ptr_d               = grant_idx + 2'd1;
      wr_addr_d              = buf_addr_q[grant_idx];
      wr_data_d              = buf_data_q[grant_idx];
    end
    buf_valid_d = buf_valid_d | accept;
    if (num_valid >= 3'd2 && conflict_q != '1) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      conflict_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      conflict_q  <= conflict_d;
    end
  end

  // Payload is qualified by buf_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumReq; i++) begin
      if (accept[i]) begin
        buf_addr_q[i] <= bus.reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        buf_data_q[i] <= bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (buf_valid_q[i]) begin
        pending[buf_addr_q[i]] = 1'b1;
      end
    end
    if (wr_en_q) begin
      pending[wr_addr_q] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign bus.reqReady      = ~buf_valid_q;
  assign bus.wrEnable      = wr_en_q;
  assign bus.wrAddr        = wr_addr_q;
  assign bus.wrData        = wr_data_q;
  assign bus.pendingMask   = pending;
  assign bus.idle          = (buf_valid_q == '0) && !wr_en_q;
  assign bus.conflictCount = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter: one default instance plus a CNT_WIDTH=2
// instance for counter saturation.
module tb_regfile_write_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  regfile_write_arbiter_if ifa ();
  regfile_write_arbiter_if #(.CNT_WIDTH(2)) ifb ();

  regfile_write_arbiter dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  regfile_write_arbiter #(.CNT_WIDTH(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] addr, input logic [31:0] data);
    ifa.reqAddr[i*5 +: 5]   = addr;
    ifa.reqData[i*32 +: 32] = data;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ifa.reqValid = '0;
    ifa.reqAddr  = '0;
    ifa.reqData  = '0;
    ifb.reqValid = '0;
    ifb.reqAddr  = '0;
    ifb.reqData  = '0;
    rst = 1'b1;
    step();

    // Reset state
    check("rst_ready",    64'(ifa.reqReady),      64'hF);
    check("rst_wren",     64'(ifa.wrEnable),      64'h0);
    check("rst_wraddr",   64'(ifa.wrAddr),        64'h0);
    check("rst_wrdata",   64'(ifa.wrData),        64'h0);
    check("rst_pending",  64'(ifa.pendingMask),   64'h0);
    check("rst_idle",     64'(ifa.idle),          64'h1);
    check("rst_conflict", 64'(ifa.conflictCount), 64'h0);
    rst = 1'b0;
    step();

    // Single write: req1 -> r5
    set_req(1, 5'd5, 32'hDEADBEEF);
    ifa.reqValid = 4'b0010;
    step();
    ifa.reqValid = 4'b0000;
    check("sw_ready_low", 64'(ifa.reqReady),    64'hD);
    check("sw_pend0",     64'(ifa.pendingMask), 64'h20);
    check("sw_wren0",     64'(ifa.wrEnable),    64'h0);
    step();
    check("sw_wren1",     64'(ifa.wrEnable),    64'h1);
    check("sw_wraddr",    64'(ifa.wrAddr),      64'h5);
    check("sw_wrdata",    64'(ifa.wrData),      64'hDEADBEEF);
    check("sw_ready_hi",  64'(ifa.reqReady),    64'hF);
    check("sw_pend1",     64'(ifa.pendingMask), 64'h20);
    step();
    check("sw_wren2",     64'(ifa.wrEnable),    64'h0);
    check("sw_pend2",     64'(ifa.pendingMask), 64'h0);
    check("sw_idle",      64'(ifa.idle),        64'h1);

    // Four-way conflict from rrPtr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    ifa.reqValid = 4'b1111;
    step();
    ifa.reqValid = 4'b0000;
    check("fw_ready", 64'(ifa.reqReady), 64'h0);
    step();
    check("fw_addr0", 64'(ifa.wrAddr),      64'h1);
    check("fw_data0", 64'(ifa.wrData),      64'h100);
    check("fw_pend",  64'(ifa.pendingMask), 64'h1E);
    step();
    check("fw_addr1", 64'(ifa.wrAddr), 64'h2);
    step();
    check("fw_addr2", 64'(ifa.wrAddr), 64'h3);
    step();
    check("fw_addr3", 64'(ifa.wrAddr),        64'h4);
    check("fw_data3", 64'(ifa.wrData),        64'h103);
    check("fw_wren3", 64'(ifa.wrEnable),      64'h1);
    check("fw_idle4", 64'(ifa.idle),          64'h0);
    step();
    check("fw_idle5", 64'(ifa.idle),          64'h1);
    check("fw_cnt",   64'(ifa.conflictCount), 64'h3);

    // Round-robin between requesters 0 and 2 held valid (rrPtr back at 0)
    set_req(0, 5'd10, 32'hA0);
    set_req(2, 5'd12, 32'hC2);
    ifa.reqValid = 4'b0101;
    step();
    step();
    check("rr_g0", 64'(ifa.wrAddr), 64'd10);
    step();
    check("rr_g1", 64'(ifa.wrAddr), 64'd12);
    check("rr_d1", 64'(ifa.wrData), 64'hC2);
    step();
    check("rr_g2", 64'(ifa.wrAddr), 64'd10);
    step();
    check("rr_g3", 64'(ifa.wrAddr), 64'd12);
    ifa.reqValid = 4'b0000;
    step();
    check("rr_g4", 64'(ifa.wrAddr), 64'd10);
    step();
    check("rr_idle", 64'(ifa.idle), 64'h1);

    // Register 0 drop on requester 3
    set_req(3, 5'd0, 32'h1234);
    ifa.reqValid = 4'b1000;
    step();
    ifa.reqValid = 4'b0000;
    check("r0_ready", 64'(ifa.reqReady),    64'hF);
    check("r0_pend",  64'(ifa.pendingMask), 64'h0);
    check("r0_wren0", 64'(ifa.wrEnable),    64'h0);
    step();
    check("r0_wren1", 64'(ifa.wrEnable),    64'h0);
    check("r0_idle",  64'(ifa.idle),        64'h1);

    // Reset with three buffers loaded
    set_req(0, 5'd7, 32'h7);
    set_req(1, 5'd8, 32'h8);
    set_req(2, 5'd9, 32'h9);
    ifa.reqValid = 4'b0111;
    step();
    ifa.reqValid = 4'b0000;
    check("mr_pend_pre", 64'(ifa.pendingMask), 64'h380);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_wren",     64'(ifa.wrEnable),      64'h0);
    check("mr_ready",    64'(ifa.reqReady),      64'hF);
    check("mr_pend",     64'(ifa.pendingMask),   64'h0);
    check("mr_conflict", 64'(ifa.conflictCount), 64'h0);
    step();
    check("mr_wren_after", 64'(ifa.wrEnable), 64'h0);
    check("mr_idle_after", 64'(ifa.idle),     64'h1);

    // Saturation on the 2-bit counter instance
    ifb.reqAddr  = {5'd4, 5'd3, 5'd2, 5'd1};
    ifb.reqValid = 4'b1111;
    step();
    check("sat_c0", 64'(ifb.conflictCount), 64'h0);
    step();
    check("sat_c1", 64'(ifb.conflictCount), 64'h1);
    step();
    check("sat_c2", 64'(ifb.conflictCount), 64'h2);
    step();
    check("sat_c3", 64'(ifb.conflictCount), 64'h3);
    step();
    step();
    check("sat_c5", 64'(ifb.conflictCount), 64'h3);
    ifb.reqValid = 4'b0000;
    for (int i = 0; i < 6; i++) step();
    check("sat_idle", 64'(ifb.idle), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
